controller_ram_arbiter: RTL and testbench
=========================================

// Module: controller_ram_arbiter
// PURPOSE
//  Shares the controller's 32-bit byte-laned ROM/RAM (1-cycle synchronous read, write-enable + 4-bit bytesel)
//  between two requesters: port A (controller CPU) and port B (loader / host upload).
//  Arbitrates per access with round-robin, plus a bounded burst lock for B.
//  Registers the memory command and routes read data back to the issuing port with a valid strobe.
// PARAMETERS
//  ADDR_WIDTH  15  word-address width, equal to the attached memory's ADDR_WIDTH
//  MAX_LOCK    64  maximum consecutive B grants under b_lock before a pending A must be served (>=1)
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  reset_n      in   1   asynchronous active-low reset
//  a_req        in   1   A access request; hold with command stable until a_ack
//  a_we         in   1   A write (1) / read (0)
//  a_bytesel    in   4   A byte enables; [3]->d[7:0] ... [0]->d[31:24]
//  a_addr       in   AW  A word address
//  a_d          in   32  A write data
//  a_ack        out  1   A command accepted this cycle (combinational)
//  a_q          out  32  A read data
//  a_qvalid     out  1   a_q valid, 1-cycle pulse per accepted A read
//  b_req/b_we/b_bytesel/b_addr/b_d/b_ack/b_q/b_qvalid   same as A, for port B
//  b_lock       in   1   B requests burst priority
//  mem_we       out  1   to memory we
//  mem_bytesel  out  4   to memory bytesel
//  mem_addr     out  AW  to memory addr
//  mem_d        out  32  to memory d
//  mem_q        in   32  from memory q
// BEHAVIOUR
//  Reset values: all outputs 0 (mem_we, mem_bytesel, mem_addr, mem_d, a/b_ack, a/b_qvalid, a/b_q);
//   last_grant=B (A wins the first tie); lock_cnt=0; read pipeline empty.
//  Grant (cycle N, combinational): at most one ack per cycle.
//   only one req -> that port; both, no lock -> port != last_grant;
//   both, b_lock=1 and last_grant=B and lock_cnt<MAX_LOCK -> B;
//   both, b_lock=1 and lock_cnt==MAX_LOCK -> A.
//  lock_cnt: +1 on each B grant while b_lock=1 (saturates at MAX_LOCK); cleared on an A grant or when b_lock=0.
//  On grant, at edge ending N: mem_* <= granted command; last_grant <= port. No grant: mem_we<=0,
//   mem_bytesel<=0; mem_addr/mem_d hold.
//  Memory samples at edge ending N+1; mem_q valid in N+2.
//  Reads: 2-stage tag pipeline {valid,owner}. In N+2, x_qvalid=1 and x_q=mem_q, registered from mem_q at
//   edge ending N+2 -> visible N+3? NO: x_q is mem_q passed through; only x_qvalid is registered. Read
//   latency is exactly 2 cycles, ack->qvalid.
//  x_q holds its last valid data when x_qvalid=0.
//  Writes produce no qvalid. Back-to-back grants are allowed every cycle, giving full throughput.
//   Responses return in issue order.
//  Read-after-write to the same address on consecutive grants returns the new data, since the write is
//   committed one edge before the read samples.
//  Requester dropping req without ack: legal, nothing issued.
//  Asynchronous reset mid-operation: in-flight reads are discarded (no qvalid); memory contents are untouched.
// STRUCTURE
//  Package ctrl_arb_pkg: OWNER_A/OWNER_B constants, typedef for the {valid,owner} pipe tag, bytesel lane mapping.
//  Sub-module ctrl_arb_pick: combinational grant from a_req, b_req, b_lock, last_grant, lock_cnt.
//  Top-level holds the registers, the mem_* mux and the response routing.
// TESTING
//  Only A reads 0x0010, memory preloaded 0x11223344 -> a_ack in N, a_qvalid in N+2 with a_q=0x11223344;
//   b_qvalid never asserts.
//  A and B both request continuously, no lock -> acks alternate A,B,A,B...; A first after reset.
//  b_lock=1, both requesting, MAX_LOCK=4 -> 4 B grants, 1 A grant, then 4 B grants.
//  B writes 0xAABBCCDD with bytesel=4'b0001 to addr 5 (old 0x00000000), next cycle A reads addr 5
//   -> a_q=0xAA000000.
//  Mixed stream R(A,1),W(B,2),R(B,3),R(A,4) back-to-back -> qvalids in order A,B,A, each exactly
//   2 cycles after its ack.
//  reset_n low in the cycle after an A read ack -> all outputs 0 immediately; no a_qvalid after release.

Source files
------------

// File: rtl/ctrl_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_arb_pkg
// Description : Shared types and constants for controller_ram_arbiter.
//               - Owner encoding for the read-response pipeline.
//               - {valid,owner} tag carried alongside each memory access.
//               - Byte-lane mapping helper: bytesel[3] -> d[7:0],
//                 bytesel[0] -> d[31:24].
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_arb_pkg;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
  } pipe_tag_t;

  // Expands a 4-bit byte select into a 32-bit bit mask using the
  // reversed lane order of the attached memory.
  function automatic logic [31:0] bytesel_mask(input logic [3:0] bytesel);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < 4; i++) begin
      mask[(24 - 8 * i) +: 8] = {8{bytesel[i]}};
    end
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_arb_pick
// Description : Combinational grant decision for controller_ram_arbiter.
//               Round-robin between A and B, with a bounded burst lock that
//               lets B keep the memory for up to MAX_LOCK consecutive grants.
// Ports       : i_a_req, i_b_req  - pending requests
//               i_b_lock          - B asks for burst priority
//               i_last_grant      - owner of the previous grant
//               i_lock_cnt        - consecutive B grants under lock
//               o_grant_a/b       - one-hot (or zero) grant this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_arb_pick
  import ctrl_arb_pkg::*;
#(
  parameter int MAX_LOCK = 64,
  parameter int LOCK_W   = 7
) (
  input  logic              i_a_req,
  input  logic              i_b_req,
  input  logic              i_b_lock,
  input  logic              i_last_grant,
  input  logic [LOCK_W-1:0] i_lock_cnt,
  output logic              o_grant_a,
  output logic              o_grant_b
);

  localparam logic [LOCK_W-1:0] c_lock_max = LOCK_W'(MAX_LOCK);

  logic w_lock_full;

  assign w_lock_full = (i_lock_cnt == c_lock_max);

  always_comb begin
    o_grant_a = 1'b0;
    o_grant_b = 1'b0;
    if (i_a_req && !i_b_req) begin
      o_grant_a = 1'b1;
    end else if (i_b_req && !i_a_req) begin
      o_grant_b = 1'b1;
    end else if (i_a_req && i_b_req) begin
      if (i_b_lock && w_lock_full) begin
        // Burst budget exhausted: the waiting A must be served now.
        o_grant_a = 1'b1;
      end else if (i_b_lock && (i_last_grant == OWNER_B)) begin
        o_grant_b = 1'b1;
      end else if (i_last_grant == OWNER_A) begin
        o_grant_b = 1'b1;
      end else begin
        o_grant_a = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/controller_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : controller_ram_arbiter
// Description : Shares a 32-bit byte-laned synchronous RAM (1-cycle read)
//               between port A (CPU) and port B (loader). One access per
//               cycle, registered memory command, read data routed back to
//               the issuing port exactly 2 cycles after its ack.
// Ports       : clk, reset_n (async active-low)
//               a_*/b_*  request ports (req/we/bytesel/addr/d in,
//                        ack/q/qvalid out), b_lock burst request
//               mem_*    memory command out, mem_q read data in
// Revision    : 1.0 - initial release
// ============================================================================
module controller_ram_arbiter
  import ctrl_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int MAX_LOCK   = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [3:0]            a_bytesel,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [31:0]           a_d,
  output logic                  a_ack,
  output logic [31:0]           a_q,
  output logic                  a_qvalid,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [3:0]            b_bytesel,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [31:0]           b_d,
  output logic                  b_ack,
  output logic [31:0]           b_q,
  output logic                  b_qvalid,
  input  logic                  b_lock,
  output logic                  mem_we,
  output logic [3:0]            mem_bytesel,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_d,
  input  logic [31:0]           mem_q
);

  localparam int                LOCK_W     = $clog2(MAX_LOCK + 1);
  localparam logic [LOCK_W-1:0] c_lock_max = LOCK_W'(MAX_LOCK);

  logic                  w_grant_a;
  logic                  w_grant_b;
  logic                  w_a_req;
  logic                  w_b_req;
  logic [LOCK_W-1:0]     w_lock_cnt_nxt;
  pipe_tag_t             w_tag1_nxt;

  logic                  r_mem_we;
  logic [3:0]            r_mem_bytesel;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_d;
  logic                  r_last_grant;
  logic [LOCK_W-1:0]     r_lock_cnt;
  pipe_tag_t             r_tag1;
  pipe_tag_t             r_tag2;
  logic [31:0]           r_a_q_hold;
  logic [31:0]           r_b_q_hold;

  // Requests are masked during reset so no ack can be seen while reset_n=0.
  assign w_a_req = a_req & reset_n;
  assign w_b_req = b_req & reset_n;

  ctrl_arb_pick #(
    .MAX_LOCK (MAX_LOCK),
    .LOCK_W   (LOCK_W)
  ) u_pick (
    .i_a_req      (w_a_req),
    .i_b_req      (w_b_req),
    .i_b_lock     (b_lock),
    .i_last_grant (r_last_grant),
    .i_lock_cnt   (r_lock_cnt),
    .o_grant_a    (w_grant_a),
    .o_grant_b    (w_grant_b)
  );

  assign a_ack = w_grant_a;
  assign b_ack = w_grant_b;

  always_comb begin
    w_lock_cnt_nxt = r_lock_cnt;
    if (w_grant_a || !b_lock) begin
      w_lock_cnt_nxt = '0;
    end else if (w_grant_b && (r_lock_cnt != c_lock_max)) begin
      w_lock_cnt_nxt = r_lock_cnt + LOCK_W'(1);
    end
  end

  // Only reads enter the response pipeline; writes leave an empty slot.
  always_comb begin
    w_tag1_nxt.valid = (w_grant_a && !a_we) || (w_grant_b && !b_we);
    w_tag1_nxt.owner = w_grant_b ? OWNER_B : OWNER_A;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_we      <= 1'b0;
      r_mem_bytesel <= 4'b0000;
      r_mem_addr    <= '0;
      r_mem_d       <= '0;
      r_last_grant  <= OWNER_B;
      r_lock_cnt    <= '0;
      r_tag1        <= '0;
      r_tag2        <= '0;
      r_a_q_hold    <= '0;
      r_b_q_hold    <= '0;
    end else begin
      if (w_grant_a) begin
        r_mem_we      <= a_we;
        r_mem_bytesel <= a_bytesel;
        r_mem_addr    <= a_addr;
        r_mem_d       <= a_d;
        r_last_grant  <= OWNER_A;
      end else if (w_grant_b) begin
        r_mem_we      <= b_we;
        r_mem_bytesel <= b_bytesel;
        r_mem_addr    <= b_addr;
        r_mem_d       <= b_d;
        r_last_grant  <= OWNER_B;
      end else begin
        // Idle cycle: kill the strobe, leave address/data parked.
        r_mem_we      <= 1'b0;
        r_mem_bytesel <= 4'b0000;
      end
      r_lock_cnt <= w_lock_cnt_nxt;
      r_tag1     <= w_tag1_nxt;
      r_tag2     <= r_tag1;
      if (a_qvalid) begin
        r_a_q_hold <= mem_q;
      end
      if (b_qvalid) begin
        r_b_q_hold <= mem_q;
      end
    end
  end

  assign mem_we      = r_mem_we;
  assign mem_bytesel = r_mem_bytesel;
  assign mem_addr    = r_mem_addr;
  assign mem_d       = r_mem_d;

  // Read data is forwarded straight from the memory in the valid cycle;
  // otherwise each port shows the last data it received.
  assign a_qvalid = r_tag2.valid && (r_tag2.owner == OWNER_A);
  assign b_qvalid = r_tag2.valid && (r_tag2.owner == OWNER_B);
  assign a_q      = a_qvalid ? mem_q : r_a_q_hold;
  assign b_q      = b_qvalid ? mem_q : r_b_q_hold;

endmodule
`default_nettype wire

// File: tb/tb_controller_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_controller_ram_arbiter
// Description : Directed self-checking bench for controller_ram_arbiter with
//               a behavioural byte-laned synchronous RAM (MAX_LOCK=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controller_ram_arbiter;

  localparam int AW = 15;

  logic          clk;
  logic          reset_n;
  logic          a_req, a_we, a_ack, a_qvalid;
  logic [3:0]    a_bytesel;
  logic [AW-1:0] a_addr;
  logic [31:0]   a_d, a_q;
  logic          b_req, b_we, b_ack, b_qvalid, b_lock;
  logic [3:0]    b_bytesel;
  logic [AW-1:0] b_addr;
  logic [31:0]   b_d, b_q;
  logic          mem_we;
  logic [3:0]    mem_bytesel;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_d;
  logic [31:0]   mem_q;

  logic [31:0]   mem [0:1023];

  int n_checks = 0;
  int n_errors = 0;

  controller_ram_arbiter #(
    .ADDR_WIDTH (AW),
    .MAX_LOCK   (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .a_req       (a_req),
    .a_we        (a_we),
    .a_bytesel   (a_bytesel),
    .a_addr      (a_addr),
    .a_d         (a_d),
    .a_ack       (a_ack),
    .a_q         (a_q),
    .a_qvalid    (a_qvalid),
    .b_req       (b_req),
    .b_we        (b_we),
    .b_bytesel   (b_bytesel),
    .b_addr      (b_addr),
    .b_d         (b_d),
    .b_ack       (b_ack),
    .b_q         (b_q),
    .b_qvalid    (b_qvalid),
    .b_lock      (b_lock),
    .mem_we      (mem_we),
    .mem_bytesel (mem_bytesel),
    .mem_addr    (mem_addr),
    .mem_d       (mem_d),
    .mem_q       (mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: bytesel[3] -> d[7:0] ... bytesel[0] -> d[31:24].
  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_bytesel[3]) mem[mem_addr[9:0]][7:0]   <= mem_d[7:0];
      if (mem_bytesel[2]) mem[mem_addr[9:0]][15:8]  <= mem_d[15:8];
      if (mem_bytesel[1]) mem[mem_addr[9:0]][23:16] <= mem_d[23:16];
      if (mem_bytesel[0]) mem[mem_addr[9:0]][31:24] <= mem_d[31:24];
    end
    mem_q <= mem[mem_addr[9:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic req, input logic we, input logic [3:0] bs,
                       input logic [AW-1:0] addr, input logic [31:0] d);
    a_req = req; a_we = we; a_bytesel = bs; a_addr = addr; a_d = d;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [3:0] bs,
                       input logic [AW-1:0] addr, input logic [31:0] d);
    b_req = req; b_we = we; b_bytesel = bs; b_addr = addr; b_d = d;
  endtask

  task automatic idle();
    set_a(1'b0, 1'b0, 4'h0, '0, 32'h0);
    set_b(1'b0, 1'b0, 4'h0, '0, 32'h0);
    b_lock = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[16] = 32'h1122_3344;
    mem[1]  = 32'hA1A1_0001;
    mem[2]  = 32'hB2B2_0002;
    mem[3]  = 32'hC3C3_0003;
    mem[4]  = 32'hD4D4_0004;

    // ---------------- reset state ----------------
    idle();
    reset_n = 1'b0;
    tick();
    tick();
    chk("rst_mem_we",      {31'd0, mem_we},      32'd0);
    chk("rst_mem_bytesel", {28'd0, mem_bytesel}, 32'd0);
    chk("rst_mem_addr",    {17'd0, mem_addr},    32'd0);
    chk("rst_mem_d",       mem_d,                32'd0);
    chk("rst_acks",        {30'd0, a_ack, b_ack},       32'd0);
    chk("rst_qvalids",     {30'd0, a_qvalid, b_qvalid}, 32'd0);
    chk("rst_a_q",         a_q, 32'd0);
    chk("rst_b_q",         b_q, 32'd0);
    reset_n = 1'b1;
    tick();

    // ---------------- single A read ----------------
    set_a(1'b1, 1'b0, 4'hF, 15'h0010, 32'h0);
    #1;
    chk("rd_a_ack", {31'd0, a_ack}, 32'd1);
    chk("rd_b_ack", {31'd0, b_ack}, 32'd0);
    tick();
    idle();
    #1;
    chk("rd_mem_addr", {17'd0, mem_addr}, 32'h10);
    chk("rd_mem_we",   {31'd0, mem_we},   32'd0);
    chk("rd_qv_n1",    {31'd0, a_qvalid}, 32'd0);
    tick();
    #1;
    chk("rd_qv_n2",  {31'd0, a_qvalid}, 32'd1);
    chk("rd_a_q",    a_q, 32'h1122_3344);
    chk("rd_b_qv",   {31'd0, b_qvalid}, 32'd0);
    tick();
    #1;
    chk("rd_qv_n3",  {31'd0, a_qvalid}, 32'd0);
    chk("rd_a_hold", a_q, 32'h1122_3344);
    chk("rd_b_qv3",  {31'd0, b_qvalid}, 32'd0);
    drain();

    // ---------------- round robin, no lock ----------------
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_a(1'b1, 1'b0, 4'hF, 15'h0001, 32'h0);
      set_b(1'b1, 1'b0, 4'hF, 15'h0003, 32'h0);
      #1;
      chk($sformatf("rr_a_ack%0d", i), {31'd0, a_ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr_b_ack%0d", i), {31'd0, b_ack}, (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
    end
    drain();

    // ---------------- B burst lock, MAX_LOCK=4 ----------------
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_a(1'b1, 1'b0, 4'hF, 15'h0001, 32'h0);
      set_b(1'b1, 1'b0, 4'hF, 15'h0003, 32'h0);
      b_lock = 1'b1;
      #1;
      chk($sformatf("lk_a_ack%0d", i), {31'd0, a_ack}, (i == 4 || i == 9) ? 32'd1 : 32'd0);
      chk($sformatf("lk_b_ack%0d", i), {31'd0, b_ack}, (i == 4 || i == 9) ? 32'd0 : 32'd1);
      tick();
    end
    drain();

    // ---------------- read after byte write ----------------
    set_b(1'b1, 1'b1, 4'b0001, 15'h0005, 32'hAABB_CCDD);
    #1;
    chk("raw_b_ack", {31'd0, b_ack}, 32'd1);
    tick();
    idle();
    set_a(1'b1, 1'b0, 4'hF, 15'h0005, 32'h0);
    #1;
    chk("raw_a_ack", {31'd0, a_ack}, 32'd1);
    tick();
    idle();
    tick();
    #1;
    chk("raw_a_qv", {31'd0, a_qvalid}, 32'd1);
    chk("raw_a_q",  a_q, 32'hAA00_0000);
    drain();

    // ---------------- mixed back-to-back stream ----------------
    // k0 R(A,1)  k1 W(B,2)  k2 R(B,3)  k3 R(A,4)
    set_a(1'b1, 1'b0, 4'hF, 15'h0001, 32'h0);
    #1;
    chk("mx0_ack", {30'd0, a_ack, b_ack}, 32'b10);
    tick();
    idle();
    set_b(1'b1, 1'b1, 4'hF, 15'h0002, 32'h2222_2222);
    #1;
    chk("mx1_ack", {30'd0, a_ack, b_ack}, 32'b01);
    chk("mx1_qv",  {30'd0, a_qvalid, b_qvalid}, 32'b00);
    tick();
    idle();
    set_b(1'b1, 1'b0, 4'hF, 15'h0003, 32'h0);
    #1;
    chk("mx2_ack", {30'd0, a_ack, b_ack}, 32'b01);
    chk("mx2_qv",  {30'd0, a_qvalid, b_qvalid}, 32'b10);
    chk("mx2_a_q", a_q, 32'hA1A1_0001);
    tick();
    idle();
    set_a(1'b1, 1'b0, 4'hF, 15'h0004, 32'h0);
    #1;
    chk("mx3_ack", {30'd0, a_ack, b_ack}, 32'b10);
    chk("mx3_qv",  {30'd0, a_qvalid, b_qvalid}, 32'b00);
    tick();
    idle();
    #1;
    chk("mx4_qv",  {30'd0, a_qvalid, b_qvalid}, 32'b01);
    chk("mx4_b_q", b_q, 32'hC3C3_0003);
    tick();
    #1;
    chk("mx5_qv",  {30'd0, a_qvalid, b_qvalid}, 32'b10);
    chk("mx5_a_q", a_q, 32'hD4D4_0004);
    tick();
    #1;
    chk("mx6_qv",  {30'd0, a_qvalid, b_qvalid}, 32'b00);
    chk("mx6_a_q", a_q, 32'hD4D4_0004);
    chk("mx6_b_q", b_q, 32'hC3C3_0003);
    chk("mx_wr2",  mem[2], 32'h2222_2222);
    drain();

    // ---------------- reset in flight ----------------
    set_a(1'b1, 1'b0, 4'hF, 15'h0010, 32'h0);
    #1;
    chk("ri_a_ack", {31'd0, a_ack}, 32'd1);
    tick();
    idle();
    reset_n = 1'b0;
    #1;
    chk("ri_mem_addr", {17'd0, mem_addr}, 32'd0);
    chk("ri_mem_we",   {28'd0, mem_bytesel, 3'd0, mem_we}, 32'd0);
    chk("ri_a_q",      a_q, 32'd0);
    chk("ri_b_q",      b_q, 32'd0);
    chk("ri_qv",       {30'd0, a_qvalid, b_qvalid}, 32'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("ri_post_qv%0d", i), {30'd0, a_qvalid, b_qvalid}, 32'd0);
      tick();
    end
    chk("ri_mem16", mem[16], 32'h1122_3344);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
